// File: rtl/bus_lane_steer_fifo.sv
// bus_lane_steer_fifo
//   Splits the input bus into NL = DATA_W/LANE_W lanes, rotates, selectively
//   inverts and masks them (in that order), then queues the steered word in a
//   DEPTH-entry FIFO with valid/ready handshakes on both sides.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers in_data
//   in_ready   a word can be accepted (low in reset and when full)
//   in_data    input word, lane k = in_data[k*LANE_W +: LANE_W]
//   lane_rot   output lane i takes input lane (i + lane_rot) mod NL
//   lane_inv   per-output-lane invert
//   lane_en    per-output-lane enable, 0 forces the lane to zero
//   out_valid  FIFO head is valid
//   out_ready  consumer takes the head
//   out_data   FIFO head, zero when empty
//   out_any    OR-reduction of out_data
//   level      occupied entries, 0..DEPTH
module bus_lane_steer_fifo #(
   parameter int DATA_W = 8,
   parameter int LANE_W = 4,
   parameter int DEPTH  = 4,
   localparam int NL = DATA_W / LANE_W,
   localparam int RW = (NL > 1) ? $clog2(NL) : 1,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RW-1:0]     lane_rot,
   input  logic [NL-1:0]     lane_inv,
   input  logic [NL-1:0]     lane_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_any,
   output logic [LW-1:0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] steer_word;
   logic [LANE_W-1:0] lane_val;
   int                src_lane;
   logic              push;
   logic              pop;

   // Rotate -> invert -> mask. With NL = 1 the modulo collapses to lane 0,
   // so lane_rot has no effect.
   always_comb begin
      steer_word = '0;
      lane_val   = '0;
      src_lane   = 0;
      for (int i = 0; i < NL; i++) begin
         src_lane = (i + int'(lane_rot)) % NL;
         lane_val = in_data[src_lane*LANE_W +: LANE_W];
         if (lane_inv[i]) lane_val = ~lane_val;
         if (!lane_en[i]) lane_val = '0;
         steer_word[i*LANE_W +: LANE_W] = lane_val;
      end
   end

   // in_ready depends only on rst_n and level, never on out_ready, so a full
   // FIFO cannot accept in the same cycle as a pop.
   assign in_ready  = rst_n && (level != FULL_LVL);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign out_any   = |out_data;

   // Storage is not reset; level gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= steer_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_lane_steer_fifo.sv
module tb_bus_lane_steer_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [0:0] lane_rot;
   logic [1:0] lane_inv;
   logic [1:0] lane_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_any;
   logic [2:0] level;

   logic        in_valid32;
   logic        in_ready32;
   logic [31:0] in_data32;
   logic [1:0]  lane_rot32;
   logic [3:0]  lane_inv32;
   logic [3:0]  lane_en32;
   logic        out_valid32;
   logic        out_ready32;
   logic [31:0] out_data32;
   logic        out_any32;
   logic [2:0]  level32;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_lane_steer_fifo u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .lane_rot(lane_rot), .lane_inv(lane_inv), .lane_en(lane_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_any(out_any), .level(level)
   );

   bus_lane_steer_fifo #(.DATA_W(32), .LANE_W(8), .DEPTH(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
      .lane_rot(lane_rot32), .lane_inv(lane_inv32), .lane_en(lane_en32),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
      .out_any(out_any32), .level(level32)
   );

   // Stimulus only: offer one word for one edge, then sample 1 time unit later.
   task automatic push_one(input logic [7:0] d, input logic r,
                           input logic [1:0] inv, input logic [1:0] en);
      in_valid = 1'b1;
      in_data  = d;
      lane_rot = r;
      lane_inv = inv;
      lane_en  = en;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_any !== 1'b0 || level !== 3'd0) begin
         n_bad++;
         $display("FAIL rst_outputs: valid=%b data=%h any=%b level=%0d want 0/00/0/0",
                  out_valid, out_data, out_any, level);
      end
      #3 rst_n = 1'b1;
      step();
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_transform();
      out_ready = 1'b1;
      push_one(8'hA5, 1'b0, 2'b01, 2'b01);
      n_cmp++;
      if (out_data !== 8'h0A || out_any !== 1'b1 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL xform_inv_mask_lo: data=%h any=%b valid=%b want 0a/1/1", out_data, out_any, out_valid);
      end
      push_one(8'hA5, 1'b0, 2'b01, 2'b10);
      n_cmp++;
      if (out_data !== 8'hA0) begin n_bad++; $display("FAIL xform_mask_hi: got %h want a0", out_data); end
      push_one(8'hA5, 1'b1, 2'b00, 2'b11);
      n_cmp++;
      if (out_data !== 8'h5A) begin n_bad++; $display("FAIL xform_rot1: got %h want 5a", out_data); end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_any !== 1'b0) begin
         n_bad++;
         $display("FAIL xform_empty: valid=%b data=%h any=%b want 0/00/0", out_valid, out_data, out_any);
      end
   endtask

   task automatic test_rotate_wide();
      out_ready32 = 1'b1;
      in_valid32  = 1'b1;
      in_data32   = 32'h11223344;
      lane_rot32  = 2'd3;
      lane_inv32  = 4'h0;
      lane_en32   = 4'hF;
      step();
      n_cmp++;
      if (out_data32 !== 32'h22334411) begin n_bad++; $display("FAIL wide_rot3: got %h want 22334411", out_data32); end
      lane_rot32 = 2'd0;
      lane_inv32 = 4'b0001;
      lane_en32  = 4'b0111;
      step();
      in_valid32 = 1'b0;
      n_cmp++;
      if (out_data32 !== 32'h002233BB) begin n_bad++; $display("FAIL wide_inv_mask: got %h want 002233bb", out_data32); end
      step();
      n_cmp++;
      if (out_valid32 !== 1'b0 || level32 !== 3'd0) begin
         n_bad++;
         $display("FAIL wide_drain: valid=%b level=%0d want 0/0", out_valid32, level32);
      end
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         push_one(8'(k), 1'b0, 2'b00, 2'b11);
         n_cmp++;
         if (level !== 3'(k)) begin n_bad++; $display("FAIL fill_level_%0d: got %0d want %0d", k, level, k); end
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
      push_one(8'h05, 1'b0, 2'b00, 2'b11);
      n_cmp++;
      if (level !== 3'd4 || out_data !== 8'h01) begin
         n_bad++;
         $display("FAIL full_reject: level=%0d head=%h want 4/01", level, out_data);
      end
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (out_data !== 8'(k) || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_%0d: data=%h valid=%b want %h/1", k, out_data, out_valid, 8'(k));
         end
         step();
         if (k == 1) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_pop: got %b want 1", in_ready); end
         end
      end
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0) begin
         n_bad++;
         $display("FAIL drain_empty: valid=%b data=%h level=%0d want 0/00/0", out_valid, out_data, level);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      push_one(8'h10, 1'b0, 2'b00, 2'b11);
      push_one(8'h11, 1'b0, 2'b00, 2'b11);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         push_one(8'h12 + 8'(k), 1'b0, 2'b00, 2'b11);
         n_cmp++;
         if (out_data !== 8'h11 + 8'(k) || level !== 3'd2) begin
            n_bad++;
            $display("FAIL b2b_%0d: data=%h level=%0d want %h/2", k, out_data, level, 8'h11 + 8'(k));
         end
      end
      step();
      step();
      n_cmp++;
      if (level !== 3'd0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_drain: level=%0d valid=%b want 0/0", level, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      push_one(8'h21, 1'b0, 2'b00, 2'b11);
      push_one(8'h22, 1'b0, 2'b00, 2'b11);
      push_one(8'h23, 1'b0, 2'b00, 2'b11);
      n_cmp++;
      if (level !== 3'd3) begin n_bad++; $display("FAIL mid_prefill: level=%0d want 3", level); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_any !== 1'b0 || level !== 3'd0 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: valid=%b data=%h any=%b level=%0d ready=%b want all 0",
                  out_valid, out_data, out_any, level, in_ready);
      end
      rst_n = 1'b1;
      push_one(8'hFF, 1'b0, 2'b00, 2'b00);
      n_cmp++;
      if (out_data !== 8'h00 || out_valid !== 1'b1 || out_any !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_after_release: data=%h valid=%b any=%b want 00/1/0", out_data, out_valid, out_any);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      lane_rot   = 1'b0;
      lane_inv   = 2'b00;
      lane_en    = 2'b00;
      out_ready  = 1'b0;
      in_valid32 = 1'b0;
      in_data32  = 32'h0;
      lane_rot32 = 2'd0;
      lane_inv32 = 4'h0;
      lane_en32  = 4'h0;
      out_ready32 = 1'b0;
      #7;
      test_reset();
      test_transform();
      test_rotate_wide();
      test_fill_drain();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
